// File: rtl/bib_bellek_yanitlayici_pkg.sv
// BIB bellek yanitlayici ortak tanimlari.
// Durum kodlari ve gecikme sayaci genisligi.
package bib_bellek_yanitlayici_pkg;

  localparam int GECIKME_W = 4;

  localparam logic [1:0] BYY_BOSTA = 2'd0;
  localparam logic [1:0] BYY_BEKLE = 2'd1;
  localparam logic [1:0] BYY_CEVAP = 2'd2;

endpackage

// File: rtl/bib_bellek_yanitlayici_dizisi.sv
// Tek portlu, senkron okumali, bayt seritli kelime RAM'i.
// Okuma once-yazma: ayni kenarda eski kelime okunur.
module bib_bellek_dizisi #(
  parameter int DERINLIK = 1024,
  parameter int AW       = $clog2(DERINLIK)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          temizle_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [31:0]   veri_i,
  output logic [31:0]   veri_o
);

  logic [31:0] mem_q [DERINLIK];
  logic [31:0] okuma_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[adr_i][8*b +: 8] <= veri_i[8*b +: 8];
      end
    end
  end

  // Cikis kaydi yalnizca istenince degisir, aksi halde tutar.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      okuma_q <= '0;
    end else if (temizle_i) begin
      okuma_q <= '0;
    end else if (en_i) begin
      okuma_q <= mem_q[adr_i];
    end
  end

  assign veri_o = okuma_q;

endmodule

// File: rtl/bib_bellek_yanitlayici.sv
// BIB veri bellegi yanitlayicisi: bekleme durumlu,
// pencere denetimli kelime erisimi.
module bib_bellek_yanitlayici
  import bib_bellek_yanitlayici_pkg::*;
#(
  parameter int          BELLEK_KELIME = 1024,
  parameter logic [31:0] TABAN_ADR     = 32'h0000_0000,
  parameter int          GECIKME       = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bib_sec_i,
  input  logic [31:0] bib_adr_i,
  input  logic [31:0] bib_veri_i,
  input  logic [3:0]  bib_veri_maske_i,
  input  logic        bib_yaz_gecerli_i,
  output logic [31:0] bib_veri_o,
  output logic        bib_durdur_o,
  output logic        bib_hata_o
);

  localparam int AW = $clog2(BELLEK_KELIME);
  localparam logic [GECIKME_W-1:0] GEC = GECIKME[GECIKME_W-1:0];

  logic [1:0]           durum_q, durum_d;
  logic [GECIKME_W-1:0] sayac_q, sayac_d;
  logic [AW-1:0]        idx_q;
  logic [31:0]          veri_q;
  logic [3:0]           maske_q;
  logic                 yaz_q, aralik_q, hata_q;

  logic [30:0]   kelime;
  logic          aralik_gir;
  logic          bosta, giris;
  logic [AW-1:0] s_idx;
  logic [31:0]   s_veri;
  logic [3:0]    s_maske;
  logic          s_yaz, s_aralik;
  logic          unused_adr;

  // Pencere denetimi kelime ofsetinde; alt iki bit yok sayilir.
  assign kelime     = {1'b0, bib_adr_i[31:2]}
                    - {1'b0, TABAN_ADR[31:2]};
  assign aralik_gir = (kelime < 31'(BELLEK_KELIME));
  assign unused_adr = ^bib_adr_i[1:0];

  assign bosta    = (durum_q == BYY_BOSTA);
  assign s_idx    = bosta ? kelime[AW-1:0] : idx_q;
  assign s_veri   = bosta ? bib_veri_i : veri_q;
  assign s_maske  = bosta ? bib_veri_maske_i : maske_q;
  assign s_yaz    = bosta ? bib_yaz_gecerli_i : yaz_q;
  assign s_aralik = bosta ? aralik_gir : aralik_q;

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    giris   = 1'b0;
    unique case (1'b1)
      (durum_q == BYY_BOSTA): begin
        if (bib_sec_i) begin
          if (GEC == '0) begin
            durum_d = BYY_CEVAP;
            giris   = 1'b1;
          end else begin
            sayac_d = GEC - 1'b1;
            durum_d = BYY_BEKLE;
          end
        end
      end
      (durum_q == BYY_BEKLE): begin
        if (!bib_sec_i) begin
          durum_d = BYY_BOSTA;
        end else if (sayac_q == '0) begin
          durum_d = BYY_CEVAP;
          giris   = 1'b1;
        end else begin
          sayac_d = sayac_q - 1'b1;
        end
      end
      (durum_q == BYY_CEVAP): durum_d = BYY_BOSTA;
      default:                durum_d = BYY_BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q  <= BYY_BOSTA;
      sayac_q  <= '0;
      idx_q    <= '0;
      veri_q   <= '0;
      maske_q  <= '0;
      yaz_q    <= 1'b0;
      aralik_q <= 1'b0;
      hata_q   <= 1'b0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
      hata_q  <= giris & ~s_aralik;
      if (bosta && bib_sec_i) begin
        idx_q    <= kelime[AW-1:0];
        veri_q   <= bib_veri_i;
        maske_q  <= bib_veri_maske_i;
        yaz_q    <= bib_yaz_gecerli_i;
        aralik_q <= aralik_gir;
      end
    end
  end

  // Yazma reset sirasinda bastirilir; RAM'in kendi reseti yok.
  logic       izin;
  logic [3:0] we;
  assign izin = giris & s_aralik & rst_ni;
  assign we   = (izin & s_yaz) ? s_maske : 4'b0000;

  bib_bellek_dizisi #(
    .DERINLIK (BELLEK_KELIME),
    .AW       (AW)
  ) u_dizi (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (izin),
    .temizle_i (giris & ~s_aralik),
    .we_i      (we),
    .adr_i     (s_idx),
    .veri_i    (s_veri),
    .veri_o    (bib_veri_o)
  );

  assign bib_durdur_o = bib_sec_i && (durum_q != BYY_CEVAP);
  assign bib_hata_o   = hata_q;

endmodule

// File: tb/tb_bib_bellek_yanitlayici.sv
// bib_bellek_yanitlayici icin kendini denetleyen sinama tezgahi.
// Uc ornek: GECIKME 0, 2 ve 3.
module tb_bib_bellek_yanitlayici;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sec  [3];
  logic [31:0] adr  [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic [3:0]  msk  [3];
  logic        yaz  [3];
  logic        dur  [3];
  logic        hata [3];

  int GD[3] = '{0, 2, 3};

  bib_bellek_yanitlayici #(.GECIKME(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bib_sec_i(sec[0]),
    .bib_adr_i(adr[0]), .bib_veri_i(wd[0]),
    .bib_veri_maske_i(msk[0]), .bib_yaz_gecerli_i(yaz[0]),
    .bib_veri_o(rd[0]), .bib_durdur_o(dur[0]),
    .bib_hata_o(hata[0]));

  bib_bellek_yanitlayici #(.GECIKME(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .bib_sec_i(sec[1]),
    .bib_adr_i(adr[1]), .bib_veri_i(wd[1]),
    .bib_veri_maske_i(msk[1]), .bib_yaz_gecerli_i(yaz[1]),
    .bib_veri_o(rd[1]), .bib_durdur_o(dur[1]),
    .bib_hata_o(hata[1]));

  bib_bellek_yanitlayici #(.GECIKME(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .bib_sec_i(sec[2]),
    .bib_adr_i(adr[2]), .bib_veri_i(wd[2]),
    .bib_veri_maske_i(msk[2]), .bib_yaz_gecerli_i(yaz[2]),
    .bib_veri_o(rd[2]), .bib_durdur_o(dur[2]),
    .bib_hata_o(hata[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request; stall count and early hata are checked here.
  task automatic run_req(input int k, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input logic w, input bit keep,
                         output logic [31:0] rv, output logic hv);
    int st;
    int eh;
    sec[k] = 1'b1; adr[k] = a; wd[k] = d; msk[k] = m; yaz[k] = w;
    st = 0; eh = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!dur[k]) break;
      st++;
      if (hata[k]) eh++;
    end
    rv = rd[k];
    hv = hata[k];
    chk("stall_cycles", 32'(st), 32'(GD[k] + 1));
    chk("early_hata", 32'(eh), 32'd0);
    @(posedge clk); #1;
    if (!keep) sec[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        w;
    bit          dc;
    logic [31:0] ev;
    logic        eh;
  } vek_t;

  vek_t        tab[$];
  logic [31:0] mdl [3][1024];
  int          wl[8] = '{0, 1, 2, 3, 4, 5, 6, 1023};

  initial begin
    logic [31:0] rv;
    logic        hv;
    int          hc;

    for (int i = 0; i < 3; i++) begin
      sec[i] = 1'b0; adr[i] = '0; wd[i] = '0;
      msk[i] = '0; yaz[i] = 1'b0;
    end
    sec[1] = 1'b1;
    #2;
    chk("rst_stall_sec", 32'(dur[1]), 32'd1);
    chk("rst_stall_idle", 32'(dur[0]), 32'd0);
    chk("rst_veri", rd[1], 32'd0);
    chk("rst_hata", 32'(hata[1]), 32'd0);
    sec[1] = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    tab.push_back('{1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 0, 0});
    tab.push_back('{1, 32'h10, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 0});
    tab.push_back('{1, 32'h10, 32'h00003000, 4'b0010, 1, 0,
                    32'hDEADBEEF, 0});
    tab.push_back('{1, 32'h10, 32'h0, 4'h0, 0, 0, 32'hDEAD30EF, 0});
    tab.push_back('{1, 32'h13, 32'h12340000, 4'b1100, 1, 0,
                    32'hDEAD30EF, 0});
    tab.push_back('{1, 32'h10, 32'h0, 4'h0, 0, 0, 32'h123430EF, 0});
    tab.push_back('{1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 0,
                    32'h123430EF, 0});
    tab.push_back('{1, 32'h10, 32'h0, 4'h0, 0, 0, 32'h123430EF, 0});
    tab.push_back('{1, 32'h0, 32'h11111111, 4'hF, 1, 1, 0, 0});
    tab.push_back('{1, 32'h1000, 32'h0, 4'h0, 0, 0, 32'h0, 1});
    tab.push_back('{1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 0, 32'h0, 1});
    tab.push_back('{1, 32'h0, 32'h0, 4'h0, 0, 0, 32'h11111111, 0});
    tab.push_back('{1, 32'hFFC, 32'h77777777, 4'hF, 1, 1, 0, 0});
    tab.push_back('{1, 32'hFFC, 32'h0, 4'h0, 0, 0, 32'h77777777, 0});
    tab.push_back('{0, 32'h0, 32'hA0A0A0A0, 4'hF, 1, 1, 0, 0});
    tab.push_back('{0, 32'h4, 32'hB1B1B1B1, 4'hF, 1, 1, 0, 0});

    foreach (tab[i]) begin
      run_req(tab[i].k, tab[i].a, tab[i].d, tab[i].m, tab[i].w,
              1'b0, rv, hv);
      if (!tab[i].dc) chk($sformatf("tab%0d_veri", i), rv, tab[i].ev);
      chk($sformatf("tab%0d_hata", i), 32'(hv), 32'(tab[i].eh));
    end

    // hata is a single-cycle pulse; veri holds afterwards
    run_req(1, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0, rv, hv);
    chk("oor_pulse", 32'(hv), 32'd1);
    @(negedge clk);
    chk("oor_pulse_end", 32'(hata[1]), 32'd0);
    chk("oor_veri_hold", rd[1], 32'd0);
    @(posedge clk); #1;

    // GECIKME=0 back-to-back with sec held high
    run_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, rv, hv);
    chk("b2b_0", rv, 32'hA0A0A0A0);
    run_req(0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b1, rv, hv);
    chk("b2b_4", rv, 32'hB1B1B1B1);
    run_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, rv, hv);
    chk("b2b_0b", rv, 32'hA0A0A0A0);

    // Abort in the second wait cycle (GECIKME=3)
    run_req(2, 32'h20, 32'h55555555, 4'hF, 1'b1, 1'b0, rv, hv);
    sec[2] = 1'b1; adr[2] = 32'h20; wd[2] = 32'hAAAAAAAA;
    msk[2] = 4'hF; yaz[2] = 1'b1;
    @(negedge clk);
    chk("abort_stall0", 32'(dur[2]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_stall1", 32'(dur[2]), 32'd1);
    @(posedge clk); #1;
    sec[2] = 1'b0;
    #1 chk("abort_stall_drop", 32'(dur[2]), 32'd0);
    hc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (hata[2]) hc++;
    end
    chk("abort_no_hata", 32'(hc), 32'd0);
    @(posedge clk); #1;
    run_req(2, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, rv, hv);
    chk("abort_old", rv, 32'h55555555);

    // Asynchronous reset during a wait state
    run_req(1, 32'h24, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, rv, hv);
    run_req(1, 32'h24, 32'h0, 4'h0, 1'b0, 1'b0, rv, hv);
    chk("pre_rst_read", rv, 32'h0BADF00D);
    sec[1] = 1'b1; adr[1] = 32'h24; wd[1] = 32'hCAFEBABE;
    msk[1] = 4'hF; yaz[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_veri", rd[1], 32'd0);
    chk("midrst_hata", 32'(hata[1]), 32'd0);
    chk("midrst_stall", 32'(dur[1]), 32'd1);
    @(posedge clk); #1;
    chk("midrst_stall2", 32'(dur[1]), 32'd1);
    sec[1] = 1'b0;
    #1 chk("midrst_stall3", 32'(dur[1]), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(1, 32'h24, 32'h0, 4'h0, 1'b0, 1'b0, rv, hv);
    chk("post_rst_read", rv, 32'h0BADF00D);

    // Randomised traffic against a word-array model
    for (int kk = 0; kk < 2; kk++) begin
      int k;
      k = (kk == 0) ? 0 : 2;
      foreach (wl[j]) begin
        logic [31:0] d;
        d = $urandom;
        run_req(k, 32'(wl[j] * 4), d, 4'hF, 1'b1, 1'b0, rv, hv);
        mdl[k][wl[j]] = d;
      end
      for (int t = 0; t < 40; t++) begin
        int          j;
        logic [31:0] a, d, ev;
        logic [3:0]  m;
        logic        w;
        bit          oor;
        j = $urandom_range(0, 8);
        if (j == 8) a = 32'h1000 + 32'($urandom_range(0, 63));
        else a = 32'(wl[j] * 4 + $urandom_range(0, 3));
        d = $urandom;
        m = 4'($urandom);
        w = 1'($urandom);
        oor = (a >= 32'd4096);
        ev = oor ? 32'd0 : mdl[k][a / 4];
        run_req(k, a, d, m, w, 1'b0, rv, hv);
        chk($sformatf("rnd%0d_%0d_veri", k, t), rv, ev);
        chk($sformatf("rnd%0d_%0d_hata", k, t), 32'(hv), 32'(oor));
        if (w && !oor) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) mdl[k][a / 4][8*b +: 8] = d[8*b +: 8];
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
